// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the MIPS-style CPU.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: index decode, optional write-first bypass,
// and forcing of register 0 to zero.
module rf_read_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0]                   rd_addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
    input  logic                                byp_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [DATA_W-1:0]                   wr_data,
    output logic [DATA_W-1:0]                   rd_data
);
    import cpu_pkg::*;

    always_comb begin
        rd_data = regs[rd_addr];
        if (BYPASS && byp_en && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
        // Zero forcing last so a bypassed write to index 0 can never leak out.
        if (rd_addr == ADDR_W'(REG_ZERO)) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32-entry GPR file: two combinational read ports, one write port, saturating write counter.
// Define REGFILE_DEBUG_PORT_EN to add a third, non-bypassed read port for board display.
module reg_file #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       ADDR_W  = 5,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_03FC,
    parameter int unsigned       BYPASS  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [15:0]       wr_count
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [15:0]                  wr_count_q, wr_count_d;
    logic                         commit;
    logic                         byp_en;

    assign commit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
    // No write commits while reset is held, so no bypass either.
    assign byp_en = wr_en && rst_n;

    always_comb begin
        wr_count_d = wr_count_q;
        if (commit && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q         <= '0;
            regs_q[REG_SP] <= SP_INIT;
            wr_count_q     <= '0;
        end else begin
            if (commit) begin
                regs_q[wr_addr] <= wr_data;
            end
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS != 0)
    ) u_port_a (
        .rd_addr (rd_addr_a),
        .regs    (regs_q),
        .byp_en  (byp_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS != 0)
    ) u_port_b (
        .rd_addr (rd_addr_b),
        .regs    (regs_q),
        .byp_en  (byp_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_b)
    );

`ifdef REGFILE_DEBUG_PORT_EN
    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (1'b0)
    ) u_port_dbg (
        .rd_addr (dbg_addr),
        .regs    (regs_q),
        .byp_en  (1'b0),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (dbg_data)
    );
`else
    // Debug read port not built.
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: read-first and write-first instances share all stimulus.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file #(.BYPASS(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_a0),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_b0),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_count  (cnt0)
    );

    reg_file #(.BYPASS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_a1),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_b1),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_count  (cnt1)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] a_rf;
        logic [31:0] a_wf;
        logic [31:0] b_rf;
        logic [31:0] b_wf;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [31:0] a0, b0, a1, b1;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] a_rf, input logic [31:0] a_wf,
                                input logic [31:0] b_rf, input logic [31:0] b_wf,
                                input logic [15:0] cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
        v.a_rf = a_rf; v.a_wf = a_wf; v.b_rf = b_rf; v.b_wf = b_wf; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        exp_t e;

        // Expected read values are those seen before the edge that commits the row's write.
        vecs[0]  = mk(1, 8,  32'hDEADBEEF, 8,  29, 0, 32'hDEADBEEF, 32'h3FC, 32'h3FC, 0);
        vecs[1]  = mk(0, 8,  32'h0, 8, 8, 32'hDEADBEEF, 32'hDEADBEEF,
                      32'hDEADBEEF, 32'hDEADBEEF, 1);
        vecs[2]  = mk(1, 0,  32'h12345678, 0, 0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(1, 5,  32'h1111, 5, 0, 0, 32'h1111, 0, 0, 1);
        vecs[4]  = mk(1, 5,  32'h2222, 5, 5, 32'h1111, 32'h2222, 32'h1111, 32'h2222, 2);
        vecs[5]  = mk(0, 5,  32'h3333, 5, 8, 32'h2222, 32'h2222,
                      32'hDEADBEEF, 32'hDEADBEEF, 3);
        vecs[6]  = mk(1, 31, 32'hA5A5A5A5, 29, 31, 32'h3FC, 32'h3FC, 0, 32'hA5A5A5A5, 3);
        vecs[7]  = mk(0, 31, 32'h0, 31, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 4);
        vecs[8]  = mk(1, 29, 32'h100, 29, 1, 32'h3FC, 32'h100, 0, 0, 4);
        vecs[9]  = mk(0, 5'bx, 32'bx, 29, 5, 32'h100, 32'h100, 32'h2222, 32'h2222, 5);
        vecs[10] = mk(0, 0,  32'h0, 1, 9, 0, 0, 0, 0, 5);

        // Reset held: contents visible combinationally.
        rd_addr_a = 29; rd_addr_b = 8;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_sp_a0", rd_a0, 32'h3FC);
        check("rst_hold_sp_a1", rd_a1, 32'h3FC);
        check("rst_hold_r8_b0", rd_b0, 0);
        check("rst_hold_cnt0", {16'h0, cnt0}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check($sformatf("rst_a0_r%0d", i), rd_a0, (i == 29) ? 32'h3FC : 32'h0);
            check($sformatf("rst_b1_r%0d", 31 - i), rd_b1, (31 - i == 29) ? 32'h3FC : 32'h0);
        end
        check("rst_cnt1", {16'h0, cnt1}, 0);

        // Table: drive after the edge, compare at the following negedge.
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
            e.a0 = vecs[i].a_rf; e.b0 = vecs[i].b_rf;
            e.a1 = vecs[i].a_wf; e.b1 = vecs[i].b_wf;
            e.cnt = vecs[i].cnt;
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty actual=0 expected=1");
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_a_rf", i), rd_a0, e.a0);
                check($sformatf("v%0d_b_rf", i), rd_b0, e.b0);
                check($sformatf("v%0d_a_wf", i), rd_a1, e.a1);
                check($sformatf("v%0d_b_wf", i), rd_b1, e.b1);
                check($sformatf("v%0d_cnt_rf", i), {16'h0, cnt0}, {16'h0, e.cnt});
                check($sformatf("v%0d_cnt_wf", i), {16'h0, cnt1}, {16'h0, e.cnt});
            end
        end

        // Async reset between edges while a write to reg 9 is pending.
        @(posedge clk);
        #1;
        wr_en = 1; wr_addr = 9; wr_data = 32'hCAFE; rd_addr_a = 9; rd_addr_b = 8;
        #1;
        check("pre_rst_a_rf", rd_a0, 0);
        check("pre_rst_a_wf", rd_a1, 32'hCAFE);
        check("pre_rst_b_rf", rd_b0, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_rf", rd_a0, 0);
        check("mid_rst_a_wf", rd_a1, 0);
        check("mid_rst_b_rf", rd_b0, 0);
        check("mid_rst_b_wf", rd_b1, 0);
        check("mid_rst_cnt0", {16'h0, cnt0}, 0);
        check("mid_rst_cnt1", {16'h0, cnt1}, 0);
        @(posedge clk);
        #1;
        wr_en = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_addr_a = 9; rd_addr_b = 29;
        #1;
        check("post_rst_r9_rf", rd_a0, 0);
        check("post_rst_r9_wf", rd_a1, 0);
        check("post_rst_sp", rd_b0, 32'h3FC);
        check("post_rst_cnt", {16'h0, cnt1}, 0);

        // Saturation: 65536 writes to reg 1.
        @(posedge clk);
        #1;
        wr_en = 1; wr_addr = 1; rd_addr_a = 1;
        for (int i = 0; i < 65536; i++) begin
            wr_data = 32'(i);
            @(posedge clk);
            #1;
            if (i == 65533) check("sat_fffe", {16'h0, cnt0}, 32'hFFFE);
            if (i == 65534) check("sat_ffff", {16'h0, cnt1}, 32'hFFFF);
        end
        wr_en = 0;
        #1;
        check("sat_hold_rf", {16'h0, cnt0}, 32'hFFFF);
        check("sat_hold_wf", {16'h0, cnt1}, 32'hFFFF);
        check("sat_r1", rd_a0, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS-style datapath.
- Sits directly downstream of the destination-register select mux: its 5-bit output drives `wr_addr`.
- Alongside `wr_addr`, the block takes the write-back data and the RegWrite control.
- Supplies operands to the ALU and store path through two read ports.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- SP_INIT, 32'h0000_03FC, reset value of register 29 ($sp); all other registers reset to 0
- BYPASS, 0, 1 = a read of the register being written this cycle returns `wr_data` (write-first); 0 = returns the stored value (read-first)

Ports:
- clk  in  1  system clock, rising edge active
- rst_n  in  1  asynchronous, active-low reset
- rd_addr_a  in  ADDR_W  read port A index (rs)
- rd_data_a  out  DATA_W  read port A data
- rd_addr_b  in  ADDR_W  read port B index (rt)
- rd_data_b  out  DATA_W  read port B data
- wr_en  in  1  register write enable (RegWrite)
- wr_addr  in  ADDR_W  write index, from the destination mux
- wr_data  in  DATA_W  write-back data
- wr_count  out  16  number of committed writes since reset, saturating

Behaviour:
- Reset:
  - Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
  - While `rst_n` = 0: every register is 0 except reg 29 = SP_INIT, and `wr_count` = 0.
  - Read outputs reflect the reset contents combinationally during reset.
- Write:
  - On a rising `clk` edge with `rst_n` = 1, `wr_en` = 1 and `wr_addr` != 0, mem[`wr_addr`] <= `wr_data`.
  - Write latency is 1 edge.
- Register 0:
  - Hardwired zero; a write to index 0 is dropped silently.
  - A read of index 0 always returns 0, including when BYPASS = 1 and `wr_addr` = 0.
- Read:
  - Both ports are purely combinational; no clock latency.
  - Ports A and B are independent; the same index on both is legal and returns identical data.
- Bypass:
  - Applies when `rd_addr_x` == `wr_addr`, `wr_en` = 1 and the index is nonzero.
  - BYPASS = 1: the port returns `wr_data` in the same cycle.
  - BYPASS = 0: the port returns the old value until the edge.
- `wr_count`:
  - Increments on each committed write; writes to reg 0 are not counted.
  - Saturates at 16'hFFFF.
- Reset mid-operation: asserting `rst_n` in the same cycle as a write discards the write; reset wins.
- X handling: `wr_en` = 0 with X on `wr_addr`/`wr_data` must not corrupt state.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- Defined:
  - Adds input `dbg_addr` [ADDR_W] and output `dbg_data` [DATA_W], for the FPGA board display.
  - `dbg_data` is a combinational third read, with no bypass (always the stored value).
- Undefined: ports absent; no extra logic.

Decomposition:
- Package `cpu_pkg`:
  - DATA_W and ADDR_W constants.
  - REG_ZERO = 5'd0 and REG_SP = 5'd29.
  - Typedefs reg_idx_t [4:0] and word_t [31:0].
- Sub-module `rf_read_port`:
  - Index decode, zero forcing and bypass select.
  - Instantiated for ports A and B, and for the debug port with bypass tied off.

Test Plan:
- Reset: hold `rst_n` = 0, then release. Expect reads of regs 0..31 = 0, except reg 29 = 32'h0000_03FC; `wr_count` = 0.
- Basic write/read: write 32'hDEADBEEF to reg 8, then read A = 8 and B = 8 next cycle. Expect both = 32'hDEADBEEF; `wr_count` = 1.
- Zero register: write 32'h12345678 to reg 0. Expect reads of reg 0 = 0 and `wr_count` unchanged, for both BYPASS values.
- Same-cycle read/write of reg 5 (old value 32'h1111, new value 32'h2222):
  - BYPASS = 0: read = 32'h1111 before the edge, 32'h2222 after.
  - BYPASS = 1: read = 32'h2222 in the same cycle.
- Async reset mid-write: drop `rst_n` between edges while `wr_en` = 1 to reg 9. Expect outputs to go to reset values immediately, without waiting for `clk`; reg 9 = 0 after release.
- Saturation: force 65,536 writes to reg 1. Expect `wr_count` = 16'hFFFF and no wrap.
